// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow FF.
// Rev 1.0 - initial release.
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             d_bit;
   logic             br_nxt;
   logic [WIDTH-1:0] r_shift;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         diff_q  <= diff_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      diff_d  = diff_q;
      br_d    = br_q;
      bout_d  = bout_q;
      cnt_d   = cnt_q;

      d_bit   = a_q[0] ^ b_q[0] ^ br_q;
      br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      r_shift = {d_bit, r_q[WIDTH-1:1]};

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               br_d    = bin_i;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = r_shift;
            br_d  = br_nxt;
            cnt_d = cnt_q + 1'b1;
            // Final bit: publish the shifted-in result directly, not r_q.
            if (cnt_q == C_LAST) begin
               diff_d  = r_shift;
               bout_d  = br_nxt;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign busy_o      = (state_q == S_CALC) || (state_q == S_DONE);
   assign diff_o      = diff_q;
   assign bout_o      = bout_q;

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b - bin, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Companion to the full adder. It is used where area matters more than latency, and serves as a reusable check of the adder (a - b followed by an add must return a).
- Operands enter on a valid/ready input handshake. The result leaves on a valid/ready output handshake.

Parameters:
WIDTH  8  operand/result width in bits; legal range WIDTH >= 2

Ports:
clk_i        input   1      clock; all logic on rising edge
rst_i        input   1      reset, synchronous, active-high
in_valid_i   input   1      operands and borrow-in valid
in_ready_o   output  1      block can accept operands (IDLE only)
a_i          input   WIDTH  minuend
b_i          input   WIDTH  subtrahend
bin_i        input   1      borrow in
out_valid_o  output  1      result valid (DONE only)
out_ready_i  input   1      consumer accepts result
diff_o       output  WIDTH  difference, a - b - bin mod 2^WIDTH
bout_o       output  1      borrow out; 1 when a < b + bin (unsigned)
busy_o       output  1      high in CALC or DONE

Behaviour:
- Reset, sampled at a rising edge with rst_i=1:
  - state=IDLE; shift registers, bit counter and borrow FF cleared.
  - diff_o=0, bout_o=0, out_valid_o=0, busy_o=0.
  - in_ready_o=1 from the first cycle after reset.
  - Reset overrides all other inputs in the same cycle.
- States:
  - IDLE: in_ready_o=1.
  - CALC: in_ready_o=0, busy_o=1.
  - DONE: out_valid_o=1, busy_o=1, in_ready_o=0.
- IDLE -> CALC on an edge with in_valid_i & in_ready_o. On that edge:
  - a_i and b_i are latched into shift registers A and B.
  - bin_i is loaded into the borrow FF.
  - the counter is cleared to 0.
- CALC, one bit per edge:
  - d = A[0] ^ B[0] ^ br
  - br_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & br)
  - A and B shift right by one.
  - d enters the MSB of result shift register R, and R shifts right.
  - the counter increments.
- CALC -> DONE on the edge where the counter equals WIDTH-1, i.e. the WIDTH-th CALC edge. On that edge:
  - diff_o is loaded with the fully assembled R, including the final bit.
  - bout_o is loaded with br_next.
- Latency: out_valid_o rises exactly WIDTH edges after the accepting edge (8 for the default).
- DONE:
  - diff_o, bout_o and out_valid_o hold stable until out_ready_i=1.
  - On that edge the state goes to IDLE and out_valid_o falls.
  - diff_o and bout_o keep their last value until the next DONE.
- Throughput: one result per WIDTH+2 cycles at best. in_ready_o is never high in the same cycle as out_valid_o.
- Inputs while not in IDLE:
  - in_valid_i, a_i, b_i and bin_i are ignored in CALC and DONE.
  - Changing operands mid-calculation has no effect on the result.
- out_ready_i is ignored outside DONE.
- Reset mid-CALC or mid-DONE:
  - the operation is aborted and no out_valid_o pulse occurs.
  - the block is back in IDLE on the next cycle.
- Wrap-around:
  - result is mod 2^WIDTH.
  - a=0, b=0, bin=1 gives diff = all ones, bout=1.
- Counter width is $clog2(WIDTH). No combinational path from any input to any output except via state.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, bin=0, out_ready_i=1 -> out_valid_o high exactly 8 edges after acceptance; diff_o=0x02, bout_o=0; in_ready_o=1 the cycle after the output handshake.
2. a=0x00, b=0x01, bin=0 -> diff_o=0xFF, bout_o=1. Then a=0xFF, b=0xFF, bin=1 -> diff_o=0xFF, bout_o=1. Then a=0x80, b=0x7F, bin=1 -> diff_o=0x00, bout_o=0.
3. Backpressure: a=0x3C, b=0x0F, out_ready_i=0 for 5 cycles in DONE -> out_valid_o, diff_o=0x2D and bout_o stay constant all 5 cycles; IDLE follows one edge after out_ready_i=1.
4. Busy-time inputs: accept a=0x10, b=0x01, then hold in_valid_i=1 with a_i=0xFF, b_i=0x00 throughout CALC/DONE -> in_ready_o=0; result is diff_o=0x0F, bout_o=0; second operand accepted only after return to IDLE.
5. Reset: assert rst_i for one edge at the 4th CALC cycle -> next cycle state IDLE, out_valid_o=0, in_ready_o=1, diff_o=0, busy_o=0. Then a=0xAA, b=0x55 -> diff_o=0x55, bout_o=0.
6. Sweep: all 256x256 a,b with bin in {0,1} against a reference model (a-b-bin) -> every diff_o and bout_o matches; every result arrives with latency 8.
